// File: rtl/udp_tx_framer.sv
// UDP/IPv4/Ethernet II transmit framer.
// Descriptor + payload stream in, complete MAC TX frame out.
module udp_tx_framer #(
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [31:0] SRC_IP      = 32'hC0A8_0180,
  parameter logic [7:0]  TTL         = 8'd64,
  parameter int          MAX_PAYLOAD = 1472
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [47:0] hdr_dst_mac,
  input  logic [31:0] hdr_dst_ip,
  input  logic [15:0] hdr_src_port,
  input  logic [15:0] hdr_dst_port,
  input  logic [15:0] hdr_length,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic        busy,
  output logic        err_oversize
);

  typedef enum logic [2:0] {
    IDLE, CSUM, HEADER, PAYLOAD, PAD, DRAIN
  } state_t;

  localparam logic [15:0] MAXP = MAX_PAYLOAD[15:0];

  state_t      state;
  logic        cphase;
  logic [47:0] dst_mac;
  logic [31:0] dst_ip;
  logic [15:0] sport;
  logic [15:0] dport;
  logic [15:0] len;
  logic [15:0] id;
  logic [31:0] sum;
  logic [15:0] csum;
  logic [15:0] pos;
  logic        err;
  logic        miss;
  logic [7:0]  m_tdata_r;
  logic        m_tvalid_r;
  logic        m_tlast_r;
  logic        m_tuser_r;

  logic [15:0]  tot_len;
  logic [15:0]  udp_len;
  logic [15:0]  last_pos;
  logic [15:0]  pos_inc;
  logic         pl_last;
  logic         in_pl;
  logic         early;
  logic         missing;
  logic         err_n;
  logic [31:0]  sum_next;
  logic [31:0]  fold1;
  logic [31:0]  fold2;
  logic [335:0] hdr_vec;
  logic [7:0]   hdr_bytes [64];
  logic [5:0]   hidx;
  logic [7:0]   hbyte;

  // Derived lengths, payload boundary flags and checksum arithmetic
  always_comb begin
    tot_len  = len + 16'd28;
    udp_len  = len + 16'd8;
    last_pos = (len < 16'd18) ? 16'd59 : len + 16'd41;
    pos_inc  = pos + 16'd1;
    pl_last  = (pos == len + 16'd41);
    in_pl    = (state == PAYLOAD);
    early    = s_tlast && !pl_last;
    missing  = pl_last && !s_tlast;
    err_n    = err || early || missing;
    sum_next = 32'h0000_4500 + {16'h0, tot_len} + {16'h0, id}
             + 32'h0000_4000 + {16'h0, TTL, 8'h11}
             + {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]}
             + {16'h0, dst_ip[31:16]} + {16'h0, dst_ip[15:0]};
    fold1    = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    fold2    = {16'h0, fold1[15:0]} + {16'h0, fold1[31:16]};
  end

  // Header image and byte selector for the next registered header byte
  always_comb begin
    hdr_vec = {dst_mac, SRC_MAC, 16'h0800, 8'h45, 8'h00,
               tot_len, id, 16'h4000, TTL, 8'h11, csum,
               SRC_IP, dst_ip, sport, dport, udp_len, 16'h0000};
    for (int k = 0; k < 42; k++)
      hdr_bytes[k] = hdr_vec[8*(41-k) +: 8];
    for (int k = 42; k < 64; k++)
      hdr_bytes[k] = 8'h00;
    hidx  = (state == HEADER) ? pos[5:0] + 6'd1 : 6'd0;
    hbyte = hdr_bytes[hidx];
  end

  // Payload passes straight through; everything else is registered
  always_comb begin
    hdr_ready = (state == IDLE);
    busy      = (state != IDLE);
    m_tdata   = in_pl ? s_tdata  : m_tdata_r;
    m_tvalid  = in_pl ? s_tvalid : m_tvalid_r;
    m_tlast   = in_pl ? (pos == last_pos) : m_tlast_r;
    m_tuser   = in_pl ? ((pos == last_pos) && err_n) : m_tuser_r;
    s_tready  = in_pl ? m_tready : (state == DRAIN);
  end

  // Framer control FSM with registered header/pad outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cphase       <= 1'b0;
      dst_mac      <= '0;
      dst_ip       <= '0;
      sport        <= '0;
      dport        <= '0;
      len          <= '0;
      id           <= '0;
      sum          <= '0;
      csum         <= '0;
      pos          <= '0;
      err          <= 1'b0;
      miss         <= 1'b0;
      m_tdata_r    <= '0;
      m_tvalid_r   <= 1'b0;
      m_tlast_r    <= 1'b0;
      m_tuser_r    <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      err_oversize <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hdr_valid) begin
            dst_mac <= hdr_dst_mac;
            dst_ip  <= hdr_dst_ip;
            sport   <= hdr_src_port;
            dport   <= hdr_dst_port;
            len     <= hdr_length;
            err     <= 1'b0;
            miss    <= 1'b0;
            pos     <= '0;
            cphase  <= 1'b0;
            if (hdr_length > MAXP) begin
              err_oversize <= 1'b1;
              state        <= DRAIN;
            end else begin
              state <= CSUM;
            end
          end
        end
        CSUM: begin
          if (!cphase) begin
            sum    <= sum_next;
            cphase <= 1'b1;
          end else begin
            csum       <= ~fold2[15:0];
            state      <= HEADER;
            m_tvalid_r <= 1'b1;
            m_tdata_r  <= hbyte;
            m_tlast_r  <= 1'b0;
            m_tuser_r  <= 1'b0;
          end
        end
        HEADER: begin
          if (m_tready) begin
            pos <= pos_inc;
            if (pos == 16'd41) begin
              if (len == 16'd0) begin
                state     <= PAD;
                m_tdata_r <= 8'h00;
              end else begin
                state      <= PAYLOAD;
                m_tvalid_r <= 1'b0;
              end
            end else begin
              m_tdata_r <= hbyte;
            end
          end
        end
        PAYLOAD: begin
          if (s_tvalid && m_tready) begin
            err  <= err_n;
            miss <= miss || missing;
            if (pos == last_pos) begin
              id    <= id + 16'd1;
              state <= missing ? DRAIN : IDLE;
            end else begin
              pos <= pos_inc;
              if (pl_last || s_tlast) begin
                state      <= PAD;
                m_tvalid_r <= 1'b1;
                m_tdata_r  <= 8'h00;
                m_tlast_r  <= (pos_inc == last_pos);
                m_tuser_r  <= (pos_inc == last_pos) && err_n;
              end
            end
          end
        end
        PAD: begin
          if (m_tready) begin
            if (m_tlast_r) begin
              id         <= id + 16'd1;
              m_tvalid_r <= 1'b0;
              m_tlast_r  <= 1'b0;
              m_tuser_r  <= 1'b0;
              state      <= miss ? DRAIN : IDLE;
            end else begin
              pos       <= pos_inc;
              m_tlast_r <= (pos_inc == last_pos);
              m_tuser_r <= (pos_inc == last_pos) && err;
            end
          end
        end
        DRAIN: begin
          if (s_tvalid && s_tlast)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Bench for udp_tx_framer: table vectors, random frames,
// oversize drain and mid-frame reset against a frame model.
module tb_udp_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hdr_valid = 1'b0;
  logic        hdr_ready;
  logic [47:0] hdr_dst_mac = '0;
  logic [31:0] hdr_dst_ip = '0;
  logic [15:0] hdr_src_port = '0;
  logic [15:0] hdr_dst_port = '0;
  logic [15:0] hdr_length = '0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        m_tuser;
  logic        busy;
  logic        err_oversize;

  always #5 clk = ~clk;

  udp_tx_framer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hdr_valid    (hdr_valid),
    .hdr_ready    (hdr_ready),
    .hdr_dst_mac  (hdr_dst_mac),
    .hdr_dst_ip   (hdr_dst_ip),
    .hdr_src_port (hdr_src_port),
    .hdr_dst_port (hdr_dst_port),
    .hdr_length   (hdr_length),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tlast      (s_tlast),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .m_tuser      (m_tuser),
    .busy         (busy),
    .err_oversize (err_oversize)
  );

  typedef struct {
    int          len;
    int          n_in;
    int          base;
    bit          rnd;
    logic [15:0] sp;
    logic [15:0] dp;
    int          total;
    int          user;
  } vec_t;

  vec_t        tbl [9];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_id = '0;
  logic [7:0]  pay_q [$];
  logic [9:0]  exp_q [$];
  logic [9:0]  got_q [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected frame from the protocol rules: header bytes, one's-complement
  // checksum with end-around carry, payload (zero after early end), padding.
  function automatic void build_exp(input int len, input int n_in);
    logic [7:0]  b [$];
    int          s;
    logic [15:0] cs;
    logic [15:0] tl;
    logic [15:0] ul;
    logic        user;
    logic [47:0] smac;
    logic [31:0] sip;
    smac = 48'h02_00_00_00_00_01;
    sip  = 32'hC0A8_0180;
    tl   = 16'(28 + len);
    ul   = 16'(8 + len);
    for (int i = 5; i >= 0; i--) b.push_back(hdr_dst_mac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(smac[8*i +: 8]);
    b.push_back(8'h08); b.push_back(8'h00);
    b.push_back(8'h45); b.push_back(8'h00);
    b.push_back(tl[15:8]); b.push_back(tl[7:0]);
    b.push_back(exp_id[15:8]); b.push_back(exp_id[7:0]);
    b.push_back(8'h40); b.push_back(8'h00);
    b.push_back(8'd64); b.push_back(8'h11);
    b.push_back(8'h00); b.push_back(8'h00);
    for (int i = 3; i >= 0; i--) b.push_back(sip[8*i +: 8]);
    for (int i = 3; i >= 0; i--) b.push_back(hdr_dst_ip[8*i +: 8]);
    b.push_back(hdr_src_port[15:8]); b.push_back(hdr_src_port[7:0]);
    b.push_back(hdr_dst_port[15:8]); b.push_back(hdr_dst_port[7:0]);
    b.push_back(ul[15:8]); b.push_back(ul[7:0]);
    b.push_back(8'h00); b.push_back(8'h00);
    s = 0;
    for (int i = 0; i < 10; i++)
      s += int'({b[14+2*i], b[15+2*i]});
    while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
    cs = ~16'(s);
    b[24] = cs[15:8];
    b[25] = cs[7:0];
    for (int i = 0; i < len; i++)
      b.push_back(i < n_in ? pay_q[i] : 8'h00);
    while (b.size() < 60) b.push_back(8'h00);
    user = (n_in != len);
    exp_q.delete();
    for (int i = 0; i < b.size(); i++) begin
      logic last;
      last = (i == b.size() - 1);
      exp_q.push_back({user && last, last, b[i]});
    end
  endfunction

  task automatic do_hs(output bit ok);
    int k;
    k = 0;
    hdr_valid = 1'b1;
    while (!hdr_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (k < 200);
    @(posedge clk); #1;
    hdr_valid = 1'b0;
  endtask

  task automatic drive_in(input bit rnd, input int ins, input int n_in,
                          input logic consumed);
    m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!s_tvalid || consumed) begin
      if (ins < n_in && (!rnd || $urandom_range(0, 2) != 0)) begin
        s_tvalid = 1'b1;
        s_tdata  = pay_q[ins];
        s_tlast  = (ins == n_in - 1);
      end else begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
      end
    end
  endtask

  task automatic run_frame(input int len, input int n_in, input bit rnd,
                           input logic [15:0] sp, input logic [15:0] dp,
                           input int tot, input int usr, input string nm);
    bit         ok;
    int         pe;
    int         ins;
    int         first_pe;
    int         stray;
    bit         out_done;
    bit         prev_stall;
    logic       consumed;
    logic [9:0] prev;
    logic [9:0] cur;
    hdr_dst_mac  = {16'($urandom), 32'($urandom)};
    hdr_dst_ip   = $urandom;
    hdr_src_port = sp;
    hdr_dst_port = dp;
    hdr_length   = 16'(len);
    build_exp(len, n_in);
    got_q.delete();
    do_hs(ok);
    if (!ok) begin
      chk({nm, "_hs_timeout"}, 32'd0, 32'd1);
      return;
    end
    pe = 1; ins = 0; first_pe = 0; stray = 0;
    out_done = 0; prev_stall = 0; prev = '0;
    consumed = 1'b0;
    s_tvalid = 1'b0;
    drive_in(rnd, ins, n_in, consumed);
    while (!(out_done && ins == n_in) && pe < 20000) begin
      @(negedge clk);
      cur = {m_tuser, m_tlast, m_tdata};
      if (prev_stall)
        chk({nm, "_stall_hold"}, 32'({m_tvalid, cur}), 32'({1'b1, prev}));
      if (m_tvalid && first_pe == 0) first_pe = pe;
      if (m_tvalid && out_done) stray++;
      prev_stall = m_tvalid && !m_tready;
      prev = cur;
      if (m_tvalid && m_tready && !out_done) begin
        got_q.push_back(cur);
        if (m_tlast) out_done = 1;
      end
      consumed = s_tvalid && s_tready;
      if (consumed) ins++;
      @(posedge clk); #1;
      pe++;
      drive_in(rnd, ins, n_in, consumed);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    if (!(out_done && ins == n_in))
      chk({nm, "_frame_timeout"}, 32'd0, 32'd1);
    chk({nm, "_first_valid_cycle"}, first_pe, 32'd3);
    chk({nm, "_nbytes"}, got_q.size(), exp_q.size());
    if (tot >= 0) chk({nm, "_total"}, got_q.size(), tot);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), 32'(got_q[i]), 32'(exp_q[i]));
    if (usr >= 0 && got_q.size() > 0)
      chk({nm, "_tuser"}, 32'(got_q[got_q.size()-1][9]), usr);
    chk({nm, "_consumed"}, ins, n_in);
    chk({nm, "_stray_valid"}, stray, 32'd0);
    chk({nm, "_ready_after"}, 32'({hdr_ready, busy}), 32'b10);
    if (out_done) exp_id = exp_id + 16'd1;
  endtask

  task automatic fill_pay(input int n, input int base, input bit rnd);
    pay_q.delete();
    for (int i = 0; i < n; i++)
      pay_q.push_back(rnd ? 8'($urandom) : 8'(base + i));
  endtask

  task automatic oversize_test();
    bit ok;
    int pulses;
    int vcnt;
    int ins;
    int cyc;
    hdr_length = 16'd1500;
    do_hs(ok);
    chk("ovs_hs", 32'(ok), 32'd1);
    pulses = 0; vcnt = 0; ins = 0; cyc = 0;
    s_tvalid = 1'b1;
    s_tdata  = 8'($urandom);
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    while (ins < 1500 && cyc < 4000) begin
      @(negedge clk);
      if (err_oversize) pulses++;
      if (m_tvalid) vcnt++;
      if (s_tvalid && s_tready) ins++;
      @(posedge clk); #1;
      cyc++;
      s_tdata = 8'($urandom);
      s_tlast = (ins == 1499);
      s_tvalid = (ins < 1500);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    chk("ovs_err_pulse_count", pulses, 32'd1);
    chk("ovs_no_output", vcnt, 32'd0);
    chk("ovs_drained", ins, 32'd1500);
    chk("ovs_ready_after", 32'(hdr_ready), 32'd1);
  endtask

  task automatic reset_mid_frame();
    bit ok;
    int ins;
    int tl;
    fill_pay(40, 0, 1);
    hdr_dst_mac = {16'($urandom), 32'($urandom)};
    hdr_dst_ip  = $urandom;
    hdr_length  = 16'd40;
    do_hs(ok);
    ins = 0; tl = 0;
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = pay_q[0];
    s_tlast  = 1'b0;
    for (int c = 0; c < 55; c++) begin
      @(negedge clk);
      if (m_tvalid && m_tready && m_tlast) tl++;
      if (s_tvalid && s_tready) ins++;
      @(posedge clk); #1;
      s_tdata = pay_q[ins];
      s_tlast = (ins == 39);
    end
    chk("rst_mid_in_payload", 32'(ins > 0 && ins < 40), 32'd1);
    #2;
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    #1;
    chk("rst_mid_outputs",
        32'({m_tvalid, m_tlast, m_tuser, s_tready, hdr_ready, busy}),
        32'b000010);
    chk("rst_mid_no_tlast", tl, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_id = 16'd0;
  endtask

  initial begin
    int len;
    int n_in;
    int mode;
    tbl[0] = '{4,    4,    'h41, 1'b0, 16'h1234, 16'h5678, 60,   0};
    tbl[1] = '{64,   64,   'h00, 1'b1, 16'h0400, 16'h0401, 106,  0};
    tbl[2] = '{20,   10,   'h10, 1'b0, 16'h0007, 16'h0009, 62,   1};
    tbl[3] = '{30,   34,   'h20, 1'b1, 16'hABCD, 16'h0035, 72,   1};
    tbl[4] = '{0,    0,    'h00, 1'b0, 16'h1000, 16'h2000, 60,   0};
    tbl[5] = '{17,   17,   'h80, 1'b1, 16'hFFFF, 16'h0001, 60,   0};
    tbl[6] = '{18,   18,   'h90, 1'b0, 16'h0050, 16'h0051, 60,   0};
    tbl[7] = '{1472, 1472, 'h00, 1'b1, 16'h4000, 16'h4001, 1514, 0};
    tbl[8] = '{5,    6,    'hC0, 1'b0, 16'h0101, 16'h0202, 60,   1};

    #2;
    chk("rst_hdr_ready", 32'(hdr_ready), 32'd1);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tlast_tuser", 32'({m_tlast, m_tuser}), 32'd0);
    chk("rst_m_tdata", 32'(m_tdata), 32'd0);
    chk("rst_busy_err", 32'({busy, err_oversize}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      fill_pay(tbl[v].n_in, tbl[v].base, 1'b0);
      run_frame(tbl[v].len, tbl[v].n_in, tbl[v].rnd, tbl[v].sp,
                tbl[v].dp, tbl[v].total, tbl[v].user,
                $sformatf("vec%0d", v));
    end

    oversize_test();
    fill_pay(8, 'h55, 1'b0);
    run_frame(8, 8, 1'b0, 16'h1111, 16'h2222, 60, 0, "post_ovs");

    for (int r = 0; r < 12; r++) begin
      mode = $urandom_range(0, 9);
      len = (mode == 0) ? 0 :
            (mode < 3) ? $urandom_range(15, 20) : $urandom_range(1, 120);
      mode = $urandom_range(0, 2);
      if (len == 0) n_in = 0;
      else if (mode == 1 && len > 1) n_in = $urandom_range(1, len - 1);
      else if (mode == 2) n_in = len + $urandom_range(1, 5);
      else n_in = len;
      fill_pay(n_in, 0, 1'b1);
      run_frame(len, n_in, 1'($urandom_range(0, 1)), 16'($urandom),
                16'($urandom), -1, -1, $sformatf("rand%0d", r));
    end

    reset_mid_frame();
    fill_pay(12, 'h30, 1'b0);
    run_frame(12, 12, 1'b0, 16'h0A0A, 16'h0B0B, 60, 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/udp_tx_framer.md
# udp_tx_framer

Transmit-side UDP/IPv4/Ethernet framer feeding the MAC TX stream. Accepts a per-frame header descriptor plus a byte-wide payload stream, emits a complete Ethernet II frame without preamble/FCS: 14-byte Ethernet, 20-byte IPv4 and 8-byte UDP headers, then the payload, zero-padded to the 60-byte minimum. It is the sending counterpart to the UDP echo datapath and replaces the echo loop wherever the fabric originates its own UDP traffic.

## Interface
- SRC_MAC, 48'h02_00_00_00_00_01, source MAC inserted in bytes 6-11
- SRC_IP, 32'hC0A8_0180, source IPv4 address (192.168.1.128)
- TTL, 8'd64, IPv4 time-to-live
- MAX_PAYLOAD, 1472, largest legal hdr_length
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- hdr_valid / hdr_ready  in / out  1 / 1  descriptor handshake
- hdr_dst_mac, hdr_dst_ip  in  48, 32  destination addresses
- hdr_src_port, hdr_dst_port  in  16, 16  UDP ports
- hdr_length  in  16  UDP payload bytes (0..MAX_PAYLOAD)
- s_tdata / s_tvalid / s_tready / s_tlast  in / in / out / in  8/1/1/1  payload stream
- m_tdata / m_tvalid / m_tready / m_tlast / m_tuser  out / out / in / out / out  8/1/1/1/1  frame stream; m_tuser = bad frame, valid with m_tlast
- busy  out  1  high in any state except IDLE
- err_oversize  out  1  one-cycle pulse on oversize descriptor

## Operation
- States: IDLE, CSUM, HEADER, PAYLOAD, PAD, DRAIN.
- IDLE: hdr_ready=1; on handshake latch all descriptor fields. hdr_length > MAX_PAYLOAD: pulse err_oversize, go DRAIN, emit nothing, IP id unchanged. Else go CSUM.
- CSUM, exactly 2 cycles: cycle 1 forms a 32-bit sum of the ten IPv4 header words (checksum field 0); cycle 2 folds the carry twice into 16 bits and inverts.
- HEADER: 42 bytes, index counter 0..41, big-endian fields: dst MAC, SRC_MAC, 0x0800, 0x45, 0x00, total length = 28+hdr_length, id, 0x4000 (DF), TTL, 0x11, checksum, SRC_IP, dst IP, src port, dst port, UDP length = 8+hdr_length, UDP checksum 0x0000.
- id: 16-bit counter, reset 0, incremented when each frame's final byte handshakes; wraps 0xFFFF->0.
- PAYLOAD: pass-through, m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready; byte counter counts to hdr_length. hdr_length=0 skips PAYLOAD.
- Early s_tlast (before byte hdr_length): set error flag; remaining payload positions are filled with 0x00 from PAD logic, s_tready=0.
- Byte hdr_length without s_tlast: set error flag and missing_last flag.
- PAD: zeros until the frame totals max(42+hdr_length, 60) bytes.
- m_tlast on the final frame byte; m_tuser = error flag on that byte, 0 otherwise.
- After final handshake: DRAIN if missing_last, else IDLE. DRAIN: s_tready=1, m_tvalid=0, discard until s_tlast handshake, then IDLE.

## Timing
- Reset (asserted, async): state IDLE, hdr_ready=1, s_tready=0, m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0, busy=0, err_oversize=0, id=0, flags cleared.
- Descriptor handshake at cycle T; first header byte valid at T+3 at the earliest.
- Header/pad bytes are registered; the payload path adds zero latency (combinational).
- m_tdata, m_tlast, m_tuser are held stable while m_tvalid && !m_tready; m_tvalid never deasserts without a handshake except under reset.
- Header to payload and payload to pad transitions have no bubble when s_tvalid and m_tready are high.
- The final handshake returns to IDLE on the next cycle (hdr_ready=1); back-to-back frames are separated by 3 idle output cycles.
- Reset mid-frame aborts at once: no m_tlast is emitted and the id is not incremented.

## Test plan
- len 4, payload 41 42 43 44, ports 0x1234->0x5678: 60 bytes, bytes 16-17=0x0020, 38-39=0x000C, bytes 46-59=0x00, m_tlast on byte 59, m_tuser=0, checksum matches the bench ones'-complement model.
- len 64, incrementing payload, m_tready 50% random, s_tvalid random: 106 bytes, payload bit-exact, no pad, outputs stable under stall.
- len 20 with s_tlast on byte 10: 62 bytes, bytes 52-61=0x00, m_tuser=1 with m_tlast on byte 61.
- len 30 with 34 input bytes, s_tlast on 34th: 72-byte frame, m_tuser=1 on byte 71, 4 extra bytes consumed with m_tvalid=0, then hdr_ready=1.
- len 1500: err_oversize one pulse, no m_tvalid, 1500 input bytes drained, next frame id unchanged.
- Two back-to-back frames carry ids 0x0000 and 0x0001; a reset during the second frame's payload is followed by a frame with id 0x0000 and a correct checksum.
